depp_regfile: RTL and testbench
===============================

// Module: depp_regfile
// PURPOSE
//  Register bank downstream of the DEPP slave front end; serves one 8-bit
//  read/write request at a time over a valid/done handshake.
//  Holds ID, scratch, LED, cycle counter, PPS counter/status and the 48-bit PIO
//  out/oe/in registers. Runs entirely in the i_clk_8mhz domain; async inputs synchronised here.
// PARAMETERS
//  ID_VALUE   8'hD5  value returned by the RO ID register (0x00)
//  UNMAP_VAL  8'hEE  read data for unmapped addresses
// PORTS
//  i_clk_8mhz   in   1   system clock, all logic on posedge
//  i_rst        in   1   reset: synchronous, active-high
//  i_req_valid  in   1   front end holds high for one request until o_req_done seen
//  i_req_write  in   1   1=write, 0=read; sampled when request accepted
//  i_req_addr   in   8   register address; sampled when accepted
//  i_req_wdata  in   8   write data; sampled when accepted
//  o_req_done   out  1   one-cycle completion pulse
//  o_req_rdata  out  8   read data; valid with o_req_done, held until next read completes
//  o_req_err    out  1   one-cycle pulse with o_req_done when address unmapped
//  i_pps        in   1   async PPS input
//  o_led        out  4   LED register bits [3:0]
//  o_pio_out    out  48  PIO output values
//  o_pio_oe     out  48  PIO output enables (1=drive)
//  i_pio_in     in   48  async PIO pin levels
// BEHAVIOUR
//  Reset: all outputs 0, all RW regs 0, counters 0, FSM to IDLE; request in flight dropped, no done.
//  FSM: IDLE -(valid & write: perform write)-> ACK; IDLE -(valid & ~write: latch addr)-> READ;
//   READ: register mux into o_req_rdata -> ACK; ACK: o_req_done=1 (o_req_err if unmapped) -> WAIT;
//   WAIT: stay until i_req_valid==0 -> IDLE. Exactly one done per request.
//  Latency: accept in cycle N; write done N+1 (reg updated at N); read done N+2.
//  Map: 0x00 ID RO | 0x01 SCRATCH RW | 0x02 LED RW [3:0], [7:4] read 0 |
//   0x03 CTRL: b0 CNT_EN RW, b1 CNT_CLR write-1 pulse, reads 0 |
//   0x04-0x07 CNT byte0..3 RO; reading 0x04 snapshots full 32-bit count into shadow,
//   0x04-0x07 return shadow bytes (coherent multi-byte read) |
//   0x08 PPS_CNT RO, 8-bit, +1 per synced i_pps rising edge, wraps FF->00 |
//   0x09 STATUS b0 PPS_SEEN sticky, write-1-to-clear |
//   0x10-0x15 PIO_OUT bytes RW | 0x18-0x1D PIO_OE bytes RW | 0x20-0x25 PIO_IN RO.
//  Byte k of a 48-bit PIO reg = bits [8k+7:8k].
//  CNT: 32-bit, +1 per clock while CNT_EN, wraps FFFFFFFF->0; CNT_CLR same cycle as increment: clear wins.
//  PPS: 2-flop sync + edge detect; edge same cycle as STATUS W1C: set wins.
//  i_pio_in: 2-flop sync before PIO_IN read.
//  Unmapped: write ignored, read returns UNMAP_VAL, o_req_err pulses with done.
//  Writes to RO regs: ignored, no error.
//  i_req_valid low in IDLE: no action. Changes to addr/data after accept: ignored.
// CONFIGURATION
//  DEPP_REGFILE_PIO_EN defined: PIO_OUT/PIO_OE/PIO_IN regs and sync logic present.
//  Not defined: 0x10-0x25 unmapped (UNMAP_VAL + o_req_err); o_pio_out=0, o_pio_oe=0, i_pio_in unused.
// TESTING
//  Reset, read 0x00 -> rdata D5, done exactly 2 cycles after accept, err=0.
//  Write 0x02=A7 then read 0x02 -> o_led=4'h7, rdata 07; write 0x01=5A, read -> 5A.
//  CTRL=01, wait 300 clks, read 0x04..0x07 -> 32-bit value within window, stable across the 4 reads;
//   CTRL=02 -> count 0.
//  256 PPS edges -> PPS_CNT 00 (wrap), STATUS b0=1; W1C 0x09 with edge same cycle -> b0 stays 1.
//  Write 0x13=C3, 0x1B=FF -> o_pio_out[31:24]=C3, o_pio_oe[31:24]=FF; i_pio_in=48'h123456789ABC,
//   read 0x20 -> BC; without DEPP_REGFILE_PIO_EN -> EE, err=1.
//  Read 0x40 -> rdata EE, err pulse; assert i_rst during READ -> no done, regs reset.

Source files
------------

// File: rtl/depp_regfile.sv
// Register bank behind the DEPP slave front end: one 8-bit request at a time over valid/done.
// Define DEPP_REGFILE_PIO_EN to build the 48-bit PIO out/oe/in registers.
module depp_regfile #(
    parameter logic [7:0] ID_VALUE  = 8'hD5,
    parameter logic [7:0] UNMAP_VAL = 8'hEE
) (
    input  logic        i_clk_8mhz,
    input  logic        i_rst,
    input  logic        i_req_valid,
    input  logic        i_req_write,
    input  logic [7:0]  i_req_addr,
    input  logic [7:0]  i_req_wdata,
    output logic        o_req_done,
    output logic [7:0]  o_req_rdata,
    output logic        o_req_err,
    input  logic        i_pps,
    output logic [3:0]  o_led,
    output logic [47:0] o_pio_out,
    output logic [47:0] o_pio_oe,
    input  logic [47:0] i_pio_in
);

    localparam int unsigned PIO_BYTES = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        ACK  = 2'd2,
        WAIT = 2'd3
    } state_t;

    state_t      state;
    logic [7:0]  addr_q;
    logic [7:0]  scratch;
    logic        cnt_en;
    logic [31:0] cnt;
    logic [31:0] cnt_shadow;
    logic        pps_s1, pps_s2, pps_prev;
    logic [7:0]  pps_cnt;
    logic        pps_seen;

    logic        wr_fire_c;
    logic        cnt_clr_c;
    logic        pps_edge_c;
    logic [7:0]  rdata_c;

    function automatic logic is_mapped(input logic [7:0] a);
        logic m;
        m = (a <= 8'h09);
`ifdef DEPP_REGFILE_PIO_EN
        m = m || (a >= 8'h10 && a <= 8'h15) || (a >= 8'h18 && a <= 8'h1D)
              || (a >= 8'h20 && a <= 8'h25);
`endif
        return m;
    endfunction

    assign wr_fire_c  = (state == IDLE) && i_req_valid && i_req_write;
    assign cnt_clr_c  = wr_fire_c && (i_req_addr == 8'h03) && i_req_wdata[1];
    assign pps_edge_c = pps_s2 && !pps_prev;

    // Request handshake; done/err are high exactly while in ACK
    always_ff @(posedge i_clk_8mhz) begin
        if (i_rst) begin
            state       <= IDLE;
            addr_q      <= 8'h00;
            o_req_done  <= 1'b0;
            o_req_err   <= 1'b0;
            o_req_rdata <= 8'h00;
        end else begin
            o_req_done <= 1'b0;
            o_req_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_req_valid) begin
                        addr_q <= i_req_addr;
                        if (i_req_write) begin
                            o_req_done <= 1'b1;
                            o_req_err  <= !is_mapped(i_req_addr);
                            state      <= ACK;
                        end else begin
                            state <= READ;
                        end
                    end
                end
                READ: begin
                    o_req_rdata <= rdata_c;
                    o_req_done  <= 1'b1;
                    o_req_err   <= !is_mapped(addr_q);
                    state       <= ACK;
                end
                ACK:  state <= WAIT;
                WAIT: if (!i_req_valid) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Scratch, LED and counter control
    always_ff @(posedge i_clk_8mhz) begin
        if (i_rst) begin
            scratch <= 8'h00;
            o_led   <= 4'h0;
            cnt_en  <= 1'b0;
        end else if (wr_fire_c) begin
            if (i_req_addr == 8'h01) scratch <= i_req_wdata;
            if (i_req_addr == 8'h02) o_led   <= i_req_wdata[3:0];
            if (i_req_addr == 8'h03) cnt_en  <= i_req_wdata[0];
        end
    end

    // Free-running cycle counter; a read of byte 0 freezes all four bytes in the shadow
    always_ff @(posedge i_clk_8mhz) begin
        if (i_rst) begin
            cnt        <= 32'h0;
            cnt_shadow <= 32'h0;
        end else begin
            if (cnt_clr_c)   cnt <= 32'h0;
            else if (cnt_en) cnt <= cnt + 32'h1;
            if (state == READ && addr_q == 8'h04) cnt_shadow <= cnt;
        end
    end

    // PPS synchroniser, edge counter and sticky flag (a new edge beats a clear)
    always_ff @(posedge i_clk_8mhz) begin
        if (i_rst) begin
            pps_s1   <= 1'b0;
            pps_s2   <= 1'b0;
            pps_prev <= 1'b0;
            pps_cnt  <= 8'h00;
            pps_seen <= 1'b0;
        end else begin
            pps_s1   <= i_pps;
            pps_s2   <= pps_s1;
            pps_prev <= pps_s2;
            if (pps_edge_c) pps_cnt <= pps_cnt + 8'h01;
            if (pps_edge_c)
                pps_seen <= 1'b1;
            else if (wr_fire_c && i_req_addr == 8'h09 && i_req_wdata[0])
                pps_seen <= 1'b0;
        end
    end

`ifdef DEPP_REGFILE_PIO_EN
    logic [47:0] pio_in_s1, pio_in_s2;

    always_ff @(posedge i_clk_8mhz) begin
        if (i_rst) begin
            o_pio_out <= 48'h0;
            o_pio_oe  <= 48'h0;
            pio_in_s1 <= 48'h0;
            pio_in_s2 <= 48'h0;
        end else begin
            pio_in_s1 <= i_pio_in;
            pio_in_s2 <= pio_in_s1;
            for (int k = 0; k < int'(PIO_BYTES); k++) begin
                if (wr_fire_c && i_req_addr == 8'(16 + k)) o_pio_out[8*k +: 8] <= i_req_wdata;
                if (wr_fire_c && i_req_addr == 8'(24 + k)) o_pio_oe[8*k +: 8]  <= i_req_wdata;
            end
        end
    end
`else
    logic unused_pio_in;
    assign unused_pio_in = ^i_pio_in;
    assign o_pio_out     = 48'h0;
    assign o_pio_oe      = 48'h0;
`endif

    // Read mux on the latched address
    always_comb begin
        rdata_c = UNMAP_VAL;
        case (addr_q)
            8'h00: rdata_c = ID_VALUE;
            8'h01: rdata_c = scratch;
            8'h02: rdata_c = {4'h0, o_led};
            8'h03: rdata_c = {7'h0, cnt_en};
            8'h04: rdata_c = cnt[7:0];
            8'h05: rdata_c = cnt_shadow[15:8];
            8'h06: rdata_c = cnt_shadow[23:16];
            8'h07: rdata_c = cnt_shadow[31:24];
            8'h08: rdata_c = pps_cnt;
            8'h09: rdata_c = {7'h0, pps_seen};
            default: rdata_c = UNMAP_VAL;
        endcase
`ifdef DEPP_REGFILE_PIO_EN
        for (int k = 0; k < int'(PIO_BYTES); k++) begin
            if (addr_q == 8'(16 + k)) rdata_c = o_pio_out[8*k +: 8];
            if (addr_q == 8'(24 + k)) rdata_c = o_pio_oe[8*k +: 8];
            if (addr_q == 8'(32 + k)) rdata_c = pio_in_s2[8*k +: 8];
        end
`endif
    end

endmodule

// File: tb/tb_depp_regfile.sv
// Directed bench for depp_regfile: handshake latency, register map, counter, PPS, PIO and reset.
module tb_depp_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_write;
    logic [7:0]  req_addr, req_wdata;
    logic        req_done, req_err;
    logic [7:0]  req_rdata;
    logic        pps;
    logic [3:0]  led;
    logic [47:0] pio_out, pio_oe, pio_in;

    int n_tests = 0;
    int n_fail  = 0;
    int n_reqs  = 0;
    int n_dones = 0;

    always #5 clk = ~clk;

    depp_regfile dut (
        .i_clk_8mhz (clk),
        .i_rst      (rst),
        .i_req_valid(req_valid),
        .i_req_write(req_write),
        .i_req_addr (req_addr),
        .i_req_wdata(req_wdata),
        .o_req_done (req_done),
        .o_req_rdata(req_rdata),
        .o_req_err  (req_err),
        .i_pps      (pps),
        .o_led      (led),
        .o_pio_out  (pio_out),
        .o_pio_oe   (pio_oe),
        .i_pio_in   (pio_in)
    );

    always @(negedge clk) if (req_done) n_dones++;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called and returns at 1 time unit after a rising edge
    task automatic bus_xfer(input logic wr, input logic [7:0] a, input logic [7:0] d,
                            output logic [7:0] rd, output logic er, output int lat);
        req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d;
        lat = 0; rd = 8'h00; er = 1'b0;
        n_reqs++;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (req_done) begin
                lat = i; rd = req_rdata; er = req_err;
                break;
            end
        end
        req_valid = 1'b0; req_addr = 8'hFF; req_wdata = 8'hFF;
        repeat (3) begin @(posedge clk); #1; end
    endtask

    task automatic do_write(input logic [7:0] a, input logic [7:0] d, input logic exp_err);
        logic [7:0] rd; logic er; int lat;
        bus_xfer(1'b1, a, d, rd, er, lat);
        check($sformatf("wr_lat_%0h", a), 64'(lat), 64'd1);
        check($sformatf("wr_err_%0h", a), 64'(er), 64'(exp_err));
    endtask

    task automatic do_read(input logic [7:0] a, output logic [7:0] rd, input logic exp_err);
        logic er; int lat;
        bus_xfer(1'b0, a, 8'h00, rd, er, lat);
        check($sformatf("rd_lat_%0h", a), 64'(lat), 64'd2);
        check($sformatf("rd_err_%0h", a), 64'(er), 64'(exp_err));
    endtask

    task automatic read_chk(input logic [7:0] a, input logic [7:0] exp, input logic exp_err);
        logic [7:0] rd;
        do_read(a, rd, exp_err);
        check($sformatf("rd_data_%0h", a), 64'(rd), 64'(exp));
    endtask

    task automatic pps_pulse();
        pps = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        pps = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
    endtask

    initial begin
        logic [7:0]  b0, b1, b2, b3, b1_again;
        logic [31:0] cval;
        logic        saw_done;

        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = 8'h00; req_wdata = 8'h00;
        pps = 1'b0; pio_in = 48'h123456789ABC;
        repeat (3) begin @(posedge clk); #1; end
        check("rst_done",  64'(req_done),  64'd0);
        check("rst_err",   64'(req_err),   64'd0);
        check("rst_rdata", 64'(req_rdata), 64'h0);
        check("rst_led",   64'(led),       64'h0);
        check("rst_pio",   64'({pio_out, pio_oe} != 96'h0), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        read_chk(8'h00, 8'hD5, 1'b0);

        do_write(8'h02, 8'hA7, 1'b0);
        check("led", 64'(led), 64'h7);
        read_chk(8'h02, 8'h07, 1'b0);
        do_write(8'h01, 8'h5A, 1'b0);
        read_chk(8'h01, 8'h5A, 1'b0);

        // RO write ignored without error; unmapped write/read flagged
        do_write(8'h00, 8'h11, 1'b0);
        read_chk(8'h00, 8'hD5, 1'b0);
        do_write(8'h40, 8'h33, 1'b1);
        read_chk(8'h40, 8'hEE, 1'b1);

        // Cycle counter
        do_write(8'h03, 8'h01, 1'b0);
        read_chk(8'h03, 8'h01, 1'b0);
        repeat (300) @(posedge clk);
        #1;
        do_read(8'h04, b0, 1'b0);
        do_read(8'h05, b1, 1'b0);
        do_read(8'h06, b2, 1'b0);
        do_read(8'h07, b3, 1'b0);
        cval = {b3, b2, b1, b0};
        check("cnt_lo", 64'(cval >= 32'd300), 64'd1);
        check("cnt_hi", 64'(cval <= 32'd320), 64'd1);
        repeat (300) @(posedge clk);
        #1;
        do_read(8'h05, b1_again, 1'b0);
        check("cnt_shadow_stable", 64'(b1_again), 64'(b1));
        do_write(8'h03, 8'h02, 1'b0);
        read_chk(8'h03, 8'h00, 1'b0);
        read_chk(8'h04, 8'h00, 1'b0);
        read_chk(8'h05, 8'h00, 1'b0);
        read_chk(8'h07, 8'h00, 1'b0);

        // PPS counter and sticky status
        read_chk(8'h09, 8'h00, 1'b0);
        repeat (5) pps_pulse();
        read_chk(8'h08, 8'h05, 1'b0);
        read_chk(8'h09, 8'h01, 1'b0);
        do_write(8'h09, 8'h01, 1'b0);
        read_chk(8'h09, 8'h00, 1'b0);
        repeat (251) pps_pulse();
        read_chk(8'h08, 8'h00, 1'b0);
        read_chk(8'h09, 8'h01, 1'b0);
        do_write(8'h09, 8'h01, 1'b0);
        read_chk(8'h09, 8'h00, 1'b0);
        // Synced edge lands on the same clock as the clear write
        pps = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        do_write(8'h09, 8'h01, 1'b0);
        pps = 1'b0;
        read_chk(8'h09, 8'h01, 1'b0);
        read_chk(8'h08, 8'h01, 1'b0);

`ifdef DEPP_REGFILE_PIO_EN
        do_write(8'h13, 8'hC3, 1'b0);
        do_write(8'h1B, 8'hFF, 1'b0);
        check("pio_out", 64'(pio_out), 64'h0000_C300_0000);
        check("pio_oe",  64'(pio_oe),  64'h0000_FF00_0000);
        read_chk(8'h13, 8'hC3, 1'b0);
        read_chk(8'h20, 8'hBC, 1'b0);
        read_chk(8'h25, 8'h12, 1'b0);
`else
        do_write(8'h13, 8'hC3, 1'b1);
        do_write(8'h1B, 8'hFF, 1'b1);
        check("pio_out", 64'(pio_out), 64'h0);
        check("pio_oe",  64'(pio_oe),  64'h0);
        read_chk(8'h20, 8'hEE, 1'b1);
`endif

        check("done_per_req", 64'(n_dones), 64'(n_reqs));

        // Reset while a read is in flight: no done, registers back to zero
        do_write(8'h03, 8'h01, 1'b0);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h01;
        @(posedge clk); #1;
        rst = 1'b1;
        saw_done = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            saw_done = saw_done | req_done;
        end
        req_valid = 1'b0;
        rst = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            saw_done = saw_done | req_done;
        end
        check("rst_inflight_done", 64'(saw_done), 64'd0);
        check("rst_led2", 64'(led), 64'h0);
        read_chk(8'h01, 8'h00, 1'b0);
        read_chk(8'h03, 8'h00, 1'b0);
        read_chk(8'h09, 8'h00, 1'b0);
        read_chk(8'h04, 8'h00, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
